// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// The state encoding doubles as the occupancy count (beats held).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic int payload_w(input int num_fields, input int field_w);
        return num_fields * field_w;
    endfunction

    // Bubble payload is all zeros (a MIPS nop); sliced down to the payload width by users.
    localparam int MAX_PAYLOAD_W = 4096;
    localparam logic [MAX_PAYLOAD_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: two-entry skid buffer with registered in_ready, synchronous
// flush to bubble, and a saturating count of downstream stall cycles.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int NUM_FIELDS = 5,
    parameter int FIELD_W    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [payload_w(NUM_FIELDS, FIELD_W)-1:0] in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [payload_w(NUM_FIELDS, FIELD_W)-1:0] out_data_o,
    output logic [1:0]                           occupancy_o,
    output logic [CNT_W-1:0]                     stall_cycles_o,
    output pipe_state_e                          state_o
);

    localparam int PW = payload_w(NUM_FIELDS, FIELD_W);
    localparam logic [PW-1:0] ZERO = BUBBLE[PW-1:0];

    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    // in_ready_o and out_valid_o come from state_q alone, never from in_valid_i/out_ready_i.
    pipe_state_e   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          accept;
    logic          pop;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_data_i;
                end
            end
            BUSY: begin
                if (accept && pop) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (pop) begin
                    state_d = EMPTY;
                    main_d  = ZERO;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                    skid_d  = ZERO;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = ZERO;
                skid_d  = ZERO;
            end
        endcase
        // Flush wins: held beats and any beat offered this cycle are discarded.
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = ZERO;
            skid_d  = ZERO;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            main_q  <= ZERO;
            skid_q  <= ZERO;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // main_q is zeroed on every path into EMPTY, so out_data is the bubble whenever idle.
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;
    assign state_o     = state_q;

    pipe_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .clear_i (1'b0),
        .inc_i   (out_valid_o && !out_ready_i),
        .count_o (stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus randomized traffic, checked by a
// queue-based reference model of the stage's contents.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int NF        = 5;
    localparam int FW        = 32;
    localparam int CW        = 4;
    localparam int PW        = NF * FW;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk_i;
    logic          reset_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [PW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [PW-1:0] out_data_o;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] stall_cycles_o;
    pipe_state_e   state_o;

    pipe_skid_reg #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .CNT_W      (CW)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .occupancy_o    (occupancy_o),
        .stall_cycles_o (stall_cycles_o),
        .state_o        (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard / reference model ----------------
    logic [PW-1:0] exp_q[$];
    int            stall_exp;
    int            chk_cnt;
    int            pass_cnt;
    int            mon_sz;
    logic [PW-1:0] mon_head;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // The model is the list of beats the stage should hold, oldest first.
    always @(negedge clk_i) begin
        if (reset_i) begin
            exp_q.delete();
            stall_exp = 0;
        end
        mon_sz = exp_q.size();
        check("occupancy", PW'(occupancy_o), PW'(mon_sz));
        check("in_ready", PW'(in_ready_o), PW'(mon_sz < 2));
        check("out_valid", PW'(out_valid_o), PW'(mon_sz > 0));
        check("stall_cycles", PW'(stall_cycles_o), PW'(stall_exp));
        if (mon_sz == 0) begin
            check("bubble_data", out_data_o, '0);
        end else if (!reset_i && out_ready_i) begin
            mon_head = exp_q.pop_front();
            check("pop_data", out_data_o, mon_head);
        end else begin
            check("head_data", out_data_o, exp_q[0]);
        end
        if (!reset_i) begin
            if (mon_sz > 0 && !out_ready_i && stall_exp < STALL_MAX) stall_exp++;
            if (flush_i) exp_q.delete();
            else if (in_valid_i && mon_sz < 2) exp_q.push_back(in_data_i);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_beat();
        logic [PW-1:0] b;
        for (int k = 0; k < NF; k++) b[k*FW +: FW] = $urandom();
        return b;
    endfunction

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
    endtask

    // Flip both handshake inputs briefly; the registered outputs must not move.
    task automatic comb_probe();
        logic iv;
        logic orr;
        iv          = in_valid_i;
        orr         = out_ready_i;
        in_valid_i  = !iv;
        out_ready_i = !orr;
        #1;
        check("in_ready_comb", PW'(in_ready_o), PW'(exp_q.size() < 2));
        check("out_valid_comb", PW'(out_valid_o), PW'(exp_q.size() > 0));
        in_valid_i  = iv;
        out_ready_i = orr;
    endtask

    // ---------------- stimulus ----------------
    logic [PW-1:0] beat;
    logic [PW-1:0] beat_a;
    logic [PW-1:0] beat_b;
    logic [PW-1:0] aaaa;
    int            pv;
    int            pr;
    int            guard;

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        stall_exp = 0;
        aaaa      = {NF{32'hAAAA_AAAA}};
        reset_i   = 1'b1;
        drive(1'b1, aaaa, 1'b1, 1'b0);
        #1;
        check("rst0_out_valid", PW'(out_valid_o), '0);
        check("rst0_in_ready", PW'(in_ready_o), PW'(1));
        step();
        step();
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Streaming: one beat per cycle, IR field (field 2) tagged.
        for (int i = 0; i < 8; i++) begin
            beat = rand_beat();
            beat[2*FW +: FW] = 32'h1000 + i;
            drive(1'b1, beat, 1'b1, 1'b0);
            step();
            check("stream_ir", PW'(out_data_o[2*FW +: FW]), PW'(32'h1000 + i));
            check("stream_occ", PW'(occupancy_o), PW'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Backpressure into the skid entry, then release in order.
        beat_a = rand_beat();
        beat_b = rand_beat();
        drive(1'b1, beat_a, 1'b1, 1'b0);
        step();
        drive(1'b1, beat_b, 1'b0, 1'b0);
        step();
        check("skid_occ", PW'(occupancy_o), PW'(2));
        check("skid_in_ready", PW'(in_ready_o), '0);
        check("skid_head", out_data_o, beat_a);
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        repeat (3) step();
        check("skid_stall", PW'(stall_cycles_o), PW'(4));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("release_b", out_data_o, beat_b);
        step();
        check("release_empty", PW'(out_valid_o), '0);

        // Flush in FULL with a beat C offered in the same cycle.
        drive(1'b1, rand_beat(), 1'b1, 1'b0);
        step();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        step();
        drive(1'b1, rand_beat(), 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("flush_out_valid", PW'(out_valid_o), '0);
        check("flush_out_data", out_data_o, '0);
        check("flush_occ", PW'(occupancy_o), '0);
        check("flush_in_ready", PW'(in_ready_o), PW'(1));
        check("flush_stall_kept", PW'(stall_cycles_o), PW'(stall_exp));
        step();

        // Asynchronous reset mid-cycle while FULL and a beat is offered.
        drive(1'b1, rand_beat(), 1'b1, 1'b0);
        step();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        step();
        drive(1'b1, aaaa, 1'b0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_out_valid", PW'(out_valid_o), '0);
        check("rst_out_data", out_data_o, '0);
        check("rst_in_ready", PW'(in_ready_o), PW'(1));
        check("rst_occ", PW'(occupancy_o), '0);
        check("rst_stall", PW'(stall_cycles_o), '0);
        step();
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();

        // Saturation: hold one beat under backpressure for 20 cycles.
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) step();
        check("sat_stall", PW'(stall_cycles_o), PW'(15));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("sat_hold", PW'(stall_cycles_o), PW'(15));

        // Randomized traffic under three valid/ready profiles.
        for (int p = 0; p < 3; p++) begin
            pv = (p == 0) ? 90 : (p == 1) ? 50 : 30;
            pr = (p == 0) ? 90 : (p == 1) ? 30 : 80;
            for (int c = 0; c < 600; c++) begin
                drive($urandom_range(0, 99) < pv, rand_beat(),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
                if (c % 7 == 3) comb_probe();
                step();
            end
        end

        // Drain with a bounded wait.
        drive(1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            step();
            guard++;
        end
        step();
        check("drain_empty", PW'(exp_q.size()), '0);
        check("drain_out_valid", PW'(out_valid_o), '0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline stage register that replaces the fixed write-enable stage registers between CPU pipeline stages. It carries NUM_FIELDS payload fields of FIELD_W bits each (e.g. V2/AO/IR/WPC/PC4) under a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered in_ready. It adds synchronous flush (bubble insertion, with bubble = all-zero payload, i.e. MIPS nop) and a saturating stall-cycle counter for performance monitoring.

## Interface
- NUM_FIELDS, 5, number of payload fields
- FIELD_W, 32, width of each field
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat (registered)
- in_data  in  NUM_FIELDS*FIELD_W  payload; field k at bits [k*FIELD_W +: FIELD_W]
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  NUM_FIELDS*FIELD_W  payload of head beat; all-zero when out_valid=0
- occupancy  out  2  beats held (0..2)
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid && !out_ready

## Operation
- accept = in_valid && in_ready; pop = out_valid && out_ready.
- Storage: main entry (drives out_data) and skid entry.
- States: EMPTY (occupancy 0), BUSY (main full, 1), FULL (main+skid, 2).
- in_ready = (state != FULL); out_valid = (state != EMPTY). Both are functions of state only, never of in_valid/out_ready.
- EMPTY: accept -> BUSY, main <= in_data.
- BUSY: accept & pop -> BUSY, main <= in_data; accept & !pop -> FULL, skid <= in_data; !accept & pop -> EMPTY, main <= 0; otherwise hold.
- FULL: pop -> BUSY, main <= skid, skid <= 0; otherwise hold. No accept is possible.
- Order is strictly FIFO; no beat is duplicated or lost except by flush.
- flush=1: next state EMPTY, main and skid <= 0. It has priority over accept and pop in the same cycle: the incoming beat is dropped, and the upstream must treat its own beat as killed. A pop in the flush cycle still completes downstream, since out_valid was already high.
- stall_cycles: increments by 1 per cycle with out_valid && !out_ready and saturates at 2^CNT_W-1. It is cleared only by reset; flush does not clear it.
- Payload fields are opaque; no arithmetic is performed on them.

## Timing
- Reset (asynchronous assert, any time, including mid-transfer):
  - state EMPTY, main = skid = 0
  - in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cycles=0
- Latency: a beat accepted at edge N is on out_data, with out_valid=1, after edge N. That is 1 cycle.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- After out_ready drops, at most one more beat is accepted, into skid. in_ready falls in the cycle after that accept.
- After flush is sampled high: out_valid=0, out_data=0, in_ready=1 from the next cycle.
- Simultaneous accept and pop in BUSY: occupancy stays 1, no bubble.

## Structure
- Shared package pipe_pkg:
  - state enum {EMPTY, BUSY, FULL}
  - localparam PAYLOAD_W = NUM_FIELDS*FIELD_W as a function
  - BUBBLE constant (all zeros)
- Sub-module pipe_sat_counter (parametrised width, inc/clear inputs, saturating), used for stall_cycles.
- Everything else lives in pipe_skid_reg.

## Test plan
- Reset check:
  - Stimulus: reset pulse asserted mid-cycle with in_valid=1, in_data=0xAAAA…
  - Required response: immediate out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cycles=0.
- Streaming:
  - Stimulus: 8 beats with IR field = 0x1000+i, in_valid=out_ready=1 continuously.
  - Required response: out_data IR=0x1000+i one cycle after each accept, no gaps, occupancy=1 throughout.
- Backpressure and skid:
  - Stimulus: out_ready=0 after beat A is accepted, then beat B offered.
  - Required response: B accepted into skid, in_ready=0, occupancy=2, stall_cycles increments each cycle. On out_ready=1: A then B, in order.
- Flush:
  - Stimulus: flush in FULL with a simultaneous in_valid beat C.
  - Required response: next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1. C never appears downstream. stall_cycles unchanged by flush.
- Saturation:
  - Stimulus: CNT_W=4, out_ready held 0 for 20 cycles with a beat held.
  - Required response: stall_cycles stops at 15 and does not wrap.
- Randomised in_valid/out_ready (directed seeds):
  - Required response: output sequence equals input sequence, and in_ready/out_valid never depend combinationally on inputs.
